uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO. It is the receive-side companion of the SOC serial port on `RXD`. It deserialises frames of configurable data width with optional parity, buffers them in a first-word-fall-through FIFO, and reports framing, parity and overrun errors. It sits between the `RXD` pad and the CPU memory-mapped IO decoder.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 12_000_000: system clock frequency.
- `BAUD_RATE`, default 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, integer-truncated. Must be ≥ 4.
- `DATA_BITS`, default 8: payload width, legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, default 16: entries, a power of 2, ≥ 2.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `RXD` in 1: serial input, asynchronous to `CLK`, idle high.
- `rd_en` in 1: pop the FIFO head. Ignored while `empty`.
- `rd_data` out `DATA_BITS`: FIFO head, valid while `!empty`.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `frame_err` out 1: one-cycle pulse; the stop bit was sampled low.
- `parity_err` out 1: one-cycle pulse; the parity bit mismatched.
- `overrun` out 1: one-cycle pulse; a good frame arrived while the FIFO was full.

## Operation
- `RXD` passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised `rxs`.
- A bit-period counter counts to `CLKS_PER_BIT-1`. A bit index counter counts up to `DATA_BITS-1`.
- IDLE: when `rxs` = 0, go to START and load the half-period count `CLKS_PER_BIT/2`.
- START: at the half-period point, sample `rxs`.
  - 1: glitch; return to IDLE with no flags.
  - 0: go to DATA with a full-period count.
- DATA: sample `rxs` every `CLKS_PER_BIT` cycles, LSB first, into the shift register. After `DATA_BITS` samples, go to PARITY if `PARITY` ≠ 0, else to STOP.
- PARITY: sample one bit.
  - Odd mode expects XOR(data, parity bit) = 1.
  - Even mode expects XOR(data, parity bit) = 0.
  - Record any mismatch, then go to STOP.
- STOP: sample one bit.
  - Stop bit = 0: pulse `frame_err`, discard the word, go to BREAK.
  - Parity mismatch recorded: pulse `parity_err`, discard the word, go to IDLE.
  - Otherwise, push the word into the FIFO and go to IDLE. If the FIFO is full, pulse `overrun` instead and discard the word.
- BREAK: wait until `rxs` = 1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- When a frame has both a framing error and a parity error, only `frame_err` is reported.
- FIFO: circular buffer with read/write pointers `$clog2(FIFO_DEPTH)` bits wide. Pointers wrap from `FIFO_DEPTH-1` to 0.
  - `rd_data` is combinational from the read pointer (first-word fall-through).
  - Simultaneous push and pop while full: both take effect, `count` is unchanged, and no `overrun`.
  - Simultaneous push and pop while empty: the push takes effect and the pop is ignored.
  - `rd_en` while empty: no effect. Pointers and `count` are unchanged.

## Timing
- Reset values: state IDLE, `empty`=1, `full`=0, `count`=0, all error pulses 0, pointers 0. `rd_data` is don't-care while `empty`.
- `RESET` asserted mid-frame aborts the frame. FIFO contents are lost and no flags pulse.
- Synchroniser latency is 2 cycles.
- A stop-bit sample at cycle N gives a FIFO write and/or error pulse at the N+1 edge. `empty`/`count`/`full` update at the same edge.
- `count`, `empty` and `full` are registered and update on the edge of a push or pop.
- Reception is continuous. The receiver returns to IDLE at mid-stop-bit and accepts the next start bit immediately, so back-to-back frames are supported.
- Each error pulse is exactly one `CLK` cycle wide.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1_000_000 and `BAUD_RATE`=100_000 (10 clocks per bit), `DATA_BITS`=8, `FIFO_DEPTH`=4, unless stated otherwise.
- Reset, then send 0xA5 -> `empty` falls about 95 cycles after the start edge. `rd_data`=0xA5, `count`=1. After `rd_en`: `empty`=1, `count`=0.
- 3-cycle low glitch on idle `RXD` -> stays in IDLE. No push and no error pulses.
- Back-to-back frames 0x01, 0x02, 0x03, 0x04, 0x05 with no reads -> `full`=1 after the fourth frame. `overrun` pulses once on 0x05. Reads return 0x01–0x04 in order.
- Fill to 4 entries, then assert `rd_en` in the push cycle of a fifth frame -> `count` stays 4, no `overrun`. Pointer wrap verified by the read order.
- Hold `RXD` low for 30 bit times -> exactly one `frame_err` pulse and no push. After `RXD` returns high, a frame 0x3C is received correctly.
- `PARITY`=2: send 0x07 with parity bit 1 (correct) -> pushed. Send 0x07 with parity bit 0 -> `parity_err` pulse and no push.
- Assert `RESET` low mid-DATA with 2 entries queued -> `empty`=1 and `count`=0 immediately. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver with an integrated first-word-fall-through receive FIFO.
// Deserialises start / DATA_BITS data (LSB first) / optional parity / stop
// frames from the RXD pad. Good words go into a circular buffer. Framing,
// parity and overrun errors are reported as single-cycle pulses.
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency
//   BAUD_RATE    line rate; CLK_FREQ_HZ / BAUD_RATE must be >= 4
//   DATA_BITS    payload width, 5..9
//   PARITY       0 = none, 1 = odd, 2 = even
//   FIFO_DEPTH   entries, power of 2, >= 2
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset
//   RXD         in   serial input, asynchronous to CLK, idle high
//   rd_en       in   pop the FIFO head (ignored while empty)
//   rd_data     out  FIFO head, valid while !empty
//   empty       out  FIFO holds 0 entries
//   full        out  FIFO holds FIFO_DEPTH entries
//   count       out  current occupancy
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   parity_err  out  one-cycle pulse, parity bit mismatched
//   overrun     out  one-cycle pulse, good word dropped because FIFO full
//
// States
//   state    | meaning
//   S_IDLE   | line idle, waiting for rxs low
//   S_START  | timing to mid start bit, rejects glitches
//   S_DATA   | sampling DATA_BITS payload bits, LSB first
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling the stop bit, deciding push / error
//   S_BREAK  | line held low after a framing error, waiting for high
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RXD,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int OCC_W        = PTR_W + 1;

    // Bit timer is a down-counter: loaded with (period - 1), sample at zero.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] DEPTH_M1  = OCC_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic             ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchroniser, idles high so reset does not look like a start bit
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   push_vld;
    logic [DATA_BITS-1:0]   push_data;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            push_vld   <= 1'b0;
            push_data  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            push_vld   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state   <= S_START;
                        bit_cnt <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rxs) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_DATA;
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        // Shift in from the top so the first bit ends at [0].
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= FULL_LOAD;
                        if (bit_idx == LAST_IDX) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        par_bad <= ((^shreg) ^ rxs) != ODD_MODE;
                        bit_cnt <= FULL_LOAD;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rxs) begin
                        // Framing error wins over a parity error.
                        frame_err <= 1'b1;
                        state     <= S_BREAK;
                    end else if (par_bad) begin
                        parity_err <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        push_vld  <= 1'b1;
                        push_data <= shreg;
                        state     <= S_IDLE;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Receive FIFO
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_pop;
    logic                 do_push;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_pop  = rd_en && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_vld && full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    empty <= 1'b0;
                    full  <= (count == DEPTH_M1);
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == OCC_ONE);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 10;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;

    logic          CLK    = 1'b0;
    logic          RESET  = 1'b0;
    logic          rxd0   = 1'b1;
    logic          rxd1   = 1'b1;
    logic          rd_en0 = 1'b0;
    logic          rd_en1 = 1'b0;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          empty0, full0, empty1, full1;
    logic [2:0]    count0, count1;
    logic          fe0, pe0, ov0, fe1, pe1, ov1;

    always #5 CLK = ~CLK;

    uart_rx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(DW),
        .PARITY(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET), .RXD(rxd0), .rd_en(rd_en0),
        .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(DW),
        .PARITY(2), .FIFO_DEPTH(DEPTH)
    ) dut_p (
        .CLK(CLK), .RESET(RESET), .RXD(rxd1), .rd_en(rd_en1),
        .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int fe_cnt0 = 0, pe_cnt0 = 0, ov_cnt0 = 0;
    int fe_cnt1 = 0, pe_cnt1 = 0, ov_cnt1 = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            exp_ov0 = 0;

    // Pulses are one cycle wide, so cycles-high equals pulse count.
    always @(negedge CLK) begin
        if (fe0) fe_cnt0++;
        if (pe0) pe_cnt0++;
        if (ov0) ov_cnt0++;
        if (fe1) fe_cnt1++;
        if (pe1) pe_cnt1++;
        if (ov1) ov_cnt1++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v, input int n);
        if (inst == 0) rxd0 = v;
        else           rxd1 = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d,
                              input bit use_par, input logic pbit);
        drive(inst, 1'b0, CPB);
        for (int i = 0; i < DW; i++) drive(inst, d[i], CPB);
        if (use_par) drive(inst, pbit, CPB);
        drive(inst, 1'b1, CPB);
    endtask

    // Scoreboard model for a good frame into the no-parity instance.
    task automatic model_push0(input logic [7:0] d);
        if (q0.size() < DEPTH) q0.push_back(d);
        else                   exp_ov0++;
    endtask

    task automatic pop_check(input int inst, input string tag);
        logic [DW-1:0] e;
        if (inst == 0) begin
            e = q0.pop_front();
            check(tag, 32'(rd_data0), 32'(e));
            rd_en0 = 1'b1;
            @(negedge CLK);
            rd_en0 = 1'b0;
        end else begin
            e = q1.pop_front();
            check(tag, 32'(rd_data1), 32'(e));
            rd_en1 = 1'b1;
            @(negedge CLK);
            rd_en1 = 1'b0;
        end
    endtask

    initial begin
        int t;
        int w;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_full",  32'(full0),  32'd0);
        check("rst_count", 32'(count0), 32'd0);
        check("rst_flags", 32'({fe0, pe0, ov0}), 32'd0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        // Single frame 0xA5 and its latency
        t = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0);
            begin
                while (empty0 && t < 200) begin
                    @(negedge CLK);
                    t++;
                end
            end
        join
        model_push0(8'hA5);
        check("a5_latency_window", 32'(t >= 93 && t <= 101), 32'd1);
        check("a5_count", 32'(count0), 32'd1);
        pop_check(0, "a5_data");
        check("a5_empty_after_rd", 32'(empty0), 32'd1);
        check("a5_count_after_rd", 32'(count0), 32'd0);

        // Short glitch on idle line
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        check("glitch_count", 32'(count0), 32'd0);
        check("glitch_flags", 32'(fe_cnt0 + pe_cnt0 + ov_cnt0), 32'd0);

        // Back-to-back frames into a 4-deep FIFO, fifth overruns
        for (int d = 1; d <= 5; d++) begin
            send_frame(0, 8'(d), 1'b0, 1'b0);
            model_push0(8'(d));
            if (d == 4) begin
                check("b2b_full_after_4", 32'(full0), 32'd1);
                check("b2b_count_after_4", 32'(count0), 32'd4);
            end
        end
        drive(0, 1'b1, 5);
        check("b2b_overrun_pulses", 32'(ov_cnt0), 32'(exp_ov0));
        check("b2b_count_after_5", 32'(count0), 32'd4);
        for (int i = 0; i < DEPTH; i++) pop_check(0, "b2b_read");
        check("b2b_empty", 32'(empty0), 32'd1);

        // Read while empty has no effect
        rd_en0 = 1'b1;
        @(negedge CLK);
        rd_en0 = 1'b0;
        check("rd_empty_count", 32'(count0), 32'd0);
        check("rd_empty_flag", 32'(empty0), 32'd1);

        // Full FIFO, pop in the push cycle of the next frame
        for (int d = 16; d < 20; d++) begin
            send_frame(0, 8'(d), 1'b0, 1'b0);
            model_push0(8'(d));
        end
        check("sim_full_before", 32'(full0), 32'd1);
        w = 0;
        fork
            send_frame(0, 8'h14, 1'b0, 1'b0);
            begin
                while (!dut.push_vld && w < 300) begin
                    @(negedge CLK);
                    w++;
                end
                check("sim_push_seen", 32'(w < 300), 32'd1);
                pop_check(0, "sim_pop_head");
            end
        join
        q0.push_back(8'h14);
        check("sim_count", 32'(count0), 32'd4);
        check("sim_no_overrun", 32'(ov_cnt0), 32'(exp_ov0));
        for (int i = 0; i < DEPTH; i++) pop_check(0, "sim_wrap_read");
        check("sim_empty", 32'(empty0), 32'd1);

        // Line held low for 30 bit times
        drive(0, 1'b0, 30 * CPB);
        drive(0, 1'b1, 2 * CPB);
        check("brk_frame_err_once", 32'(fe_cnt0), 32'd1);
        check("brk_no_push", 32'(count0), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        model_push0(8'h3C);
        check("brk_recover_count", 32'(count0), 32'd1);
        pop_check(0, "brk_recover_data");
        check("brk_no_extra_fe", 32'(fe_cnt0), 32'd1);

        // Even parity instance
        send_frame(1, 8'h07, 1'b1, 1'b1);
        q1.push_back(8'h07);
        check("par_good_count", 32'(count1), 32'd1);
        send_frame(1, 8'h07, 1'b1, 1'b0);
        check("par_bad_pulse", 32'(pe_cnt1), 32'd1);
        check("par_bad_no_push", 32'(count1), 32'd1);
        check("par_no_fe", 32'(fe_cnt1), 32'd0);
        pop_check(1, "par_good_data");

        // Reset mid-frame with two entries queued
        send_frame(0, 8'h55, 1'b0, 1'b0);
        model_push0(8'h55);
        send_frame(0, 8'hAA, 1'b0, 1'b0);
        model_push0(8'hAA);
        check("rstm_count_before", 32'(count0), 32'd2);
        fork
            send_frame(0, 8'h99, 1'b0, 1'b0);
            begin
                repeat (40) @(negedge CLK);
                RESET = 1'b0;
                #1;
                check("rstm_empty", 32'(empty0), 32'd1);
                check("rstm_count", 32'(count0), 32'd0);
            end
        join
        q0.delete();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        drive(0, 1'b1, 20);
        check("rstm_no_flags", 32'(fe_cnt0 + pe_cnt0 + ov_cnt0), 32'(1 + 0 + exp_ov0));
        check("rstm_idle_count", 32'(count0), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        model_push0(8'h5A);
        check("rstm_next_count", 32'(count0), 32'd1);
        pop_check(0, "rstm_next_data");
        check("rstm_final_empty", 32'(empty0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
